// File: rtl/score_counter_bcd.sv
// BCD score/high-score engine with text-grid character lookup. Optional SCORE_LEADING_ZERO_BLANK_EN blanks leading zeros.
// Latency: accept at edge N, final score after edge N+DIGITS+1 (one digit per clock, LSB first); char_code is combinational.
// Backpressure: add_ready low from accept through the DONE cycle; add_valid is ignored while busy and must be held.
module score_counter_bcd #(
    parameter int DIGITS     = 3,
    parameter int ADD_DIGITS = 2,
    parameter bit SATURATE   = 1'b1,
    parameter int LABEL_COL  = 7
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    module_en,
    input  logic                    clear,
    input  logic                    add_valid,
    output logic                    add_ready,
    input  logic [4*ADD_DIGITS-1:0] add_value,
    input  logic                    commit,
    output logic [4*DIGITS-1:0]     score_bcd,
    output logic [4*DIGITS-1:0]     high_bcd,
    output logic                    overflow,
    input  logic [7:0]              char_xy,
    output logic [6:0]              char_code
);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t              state, state_nxt;
    logic [IW-1:0]       idx;
    logic [4*DIGITS-1:0] addend;
    logic [4*DIGITS-1:0] addend_in;
    logic                carry;
    logic                commit_pend;
    logic                kill;
    logic [3:0]          cur_digit;
    logic [3:0]          add_digit;
    logic [4:0]          sum;
    logic [3:0]          digit_new;

    assign kill = clear | ~module_en;

    // Addend is clamped per digit and zero-extended to the score width at accept time.
    always_comb begin
        addend_in = '0;
        for (int i = 0; i < ADD_DIGITS; i++) begin
            addend_in[4*i +: 4] = (add_value[4*i +: 4] > 4'd9) ? 4'd9 : add_value[4*i +: 4];
        end
    end

    always_comb begin
        cur_digit = score_bcd[4*idx +: 4];
        add_digit = addend[4*idx +: 4];
        sum       = {1'b0, cur_digit} + {1'b0, add_digit} + {4'b0000, carry};
        digit_new = (sum > 5'd9) ? 4'(sum - 5'd10) : sum[3:0];
    end

    always_comb begin
        state_nxt = state;
        add_ready = (state == IDLE);
        case (state)
            IDLE:    if (add_valid) state_nxt = ADD;
            ADD:     if (idx == IW'(DIGITS - 1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (kill) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            score_bcd <= '0;
            overflow  <= 1'b0;
            idx       <= '0;
            carry     <= 1'b0;
            addend    <= '0;
        end else begin
            state <= state_nxt;
            if (kill) begin
                score_bcd <= '0;
                overflow  <= 1'b0;
                carry     <= 1'b0;
                idx       <= '0;
            end else begin
                case (state)
                    IDLE: if (add_valid) begin
                        addend <= addend_in;
                        carry  <= 1'b0;
                        idx    <= '0;
                    end
                    ADD: begin
                        score_bcd[4*idx +: 4] <= digit_new;
                        carry                 <= (sum > 5'd9);
                        idx                   <= idx + 1'b1;
                    end
                    DONE: if (carry) begin
                        overflow <= 1'b1;
                        if (SATURATE) score_bcd <= {DIGITS{4'h9}};
                    end
                    default: ;
                endcase
            end
        end
    end

    // Commit sees the pre-clear score; a commit arriving while busy waits for the first IDLE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            high_bcd    <= '0;
            commit_pend <= 1'b0;
        end else if (state == IDLE) begin
            if ((commit || commit_pend) && (score_bcd > high_bcd)) high_bcd <= score_bcd;
            commit_pend <= 1'b0;
        end else if (commit) begin
            commit_pend <= 1'b1;
        end
    end

    function automatic logic [6:0] label_char(input logic best, input logic [3:0] c);
        logic [6:0] ch;
        case (c)
            4'd0:    ch = best ? 7'h42 : 7'h53;
            4'd1:    ch = best ? 7'h65 : 7'h63;
            4'd2:    ch = best ? 7'h73 : 7'h6F;
            4'd3:    ch = best ? 7'h74 : 7'h72;
            4'd4:    ch = best ? 7'h3A : 7'h65;
            4'd5:    ch = best ? 7'h20 : 7'h3A;
            default: ch = 7'h20;
        endcase
        return ch;
    endfunction

    logic [3:0]          col;
    logic [3:0]          row;
    logic [4*DIGITS-1:0] disp;
    logic [3:0]          dig;
    int                  char_pos;

`ifdef SCORE_LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] lead_zero;
    logic              zero_run;

    always_comb begin
        lead_zero = '0;
        zero_run  = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run     = zero_run & (disp[4*i +: 4] == 4'd0);
            lead_zero[i] = zero_run;
        end
    end
`endif

    always_comb begin
        col       = char_xy[7:4];
        row       = char_xy[3:0];
        disp      = (row == 4'd0) ? score_bcd : high_bcd;
        char_code = 7'h00;
        dig       = 4'd0;
        char_pos  = 0;
        if (row < 4'd2) begin
            if (int'(col) >= LABEL_COL && int'(col) < LABEL_COL + DIGITS) begin
                char_pos  = DIGITS - 1 - (int'(col) - LABEL_COL);
                dig       = disp[4*char_pos +: 4];
                char_code = 7'h30 + {3'b000, dig};
`ifdef SCORE_LEADING_ZERO_BLANK_EN
                if (lead_zero[char_pos]) char_code = 7'h20;
`endif
            end else if (col < 4'd7) begin
                char_code = label_char(row[0], col);
            end
        end
    end

endmodule

// File: tb/tb_score_counter_bcd.sv
// Randomized bench for score_counter_bcd: an arithmetic score model checks a saturating and a wrapping instance every cycle.
module tb_score_counter_bcd;

    localparam int D  = 3;
    localparam int AD = 2;
    localparam int LC = 7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          module_en = 1'b0;
    logic          clear = 1'b0;
    logic          add_valid = 1'b0;
    logic          commit = 1'b0;
    logic [4*AD-1:0] add_value = '0;
    logic [7:0]    char_xy = '0;

    logic          rdy_s, rdy_w, ovf_s, ovf_w;
    logic [4*D-1:0] score_s, score_w, high_s, high_w;
    logic [6:0]    ch_s, ch_w;

    int tests = 0;
    int fails = 0;
    int last_busy;

    always #5 clk = ~clk;

    score_counter_bcd #(.DIGITS(D), .ADD_DIGITS(AD), .SATURATE(1'b1), .LABEL_COL(LC)) dut (
        .clk(clk), .rst_n(rst_n), .module_en(module_en), .clear(clear),
        .add_valid(add_valid), .add_ready(rdy_s), .add_value(add_value), .commit(commit),
        .score_bcd(score_s), .high_bcd(high_s), .overflow(ovf_s),
        .char_xy(char_xy), .char_code(ch_s));

    score_counter_bcd #(.DIGITS(D), .ADD_DIGITS(AD), .SATURATE(1'b0), .LABEL_COL(LC)) dut_w (
        .clk(clk), .rst_n(rst_n), .module_en(module_en), .clear(clear),
        .add_valid(add_valid), .add_ready(rdy_w), .add_value(add_value), .commit(commit),
        .score_bcd(score_w), .high_bcd(high_w), .overflow(ovf_w),
        .char_xy(char_xy), .char_code(ch_w));

    // Model: index 0 = saturating instance, 1 = wrapping instance; scores kept as plain integers.
    int  m_score [2];
    int  m_high  [2];
    int  m_old   [2];
    bit  m_ovf   [2];
    int  m_add;
    int  m_phase;
    bit  m_pend;
    int  tot;
    string lbl0 = "Score: ";
    string lbl1 = "Best:  ";

    function automatic int pow10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic int clamp_val(input logic [4*AD-1:0] v);
        int r = 0;
        int d;
        for (int i = 0; i < AD; i++) begin
            d = int'(v[4*i +: 4]);
            if (d > 9) d = 9;
            r = r + d * pow10(i);
        end
        return r;
    endfunction

    function automatic logic [4*D-1:0] to_bcd(input int v);
        logic [4*D-1:0] r = '0;
        for (int i = 0; i < D; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
        return r;
    endfunction

    function automatic logic [6:0] exp_char(input int s, input int h, input logic [7:0] xy);
        int row = int'(xy[3:0]);
        int col = int'(xy[7:4]);
        int val;
        int p;
        if (row >= 2) return 7'h00;
        val = (row == 0) ? s : h;
        if (col >= LC && col < LC + D) begin
            p = pow10(D - 1 - (col - LC));
`ifdef SCORE_LEADING_ZERO_BLANK_EN
            if ((col - LC) < D - 1 && val < p) return 7'h20;
`endif
            return 7'(8'h30 + (val / p) % 10);
        end
        if (col < 7) return (row == 0) ? 7'(lbl0.getc(col)) : 7'(lbl1.getc(col));
        return 7'h00;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < 2; v++) begin
                m_score[v] = 0; m_high[v] = 0; m_ovf[v] = 1'b0; m_old[v] = 0;
            end
            m_phase = 0; m_pend = 1'b0; m_add = 0;
        end else begin
            if (m_phase == 0) begin
                if (commit || m_pend)
                    for (int v = 0; v < 2; v++) if (m_score[v] > m_high[v]) m_high[v] = m_score[v];
                m_pend = 1'b0;
            end else if (commit) begin
                m_pend = 1'b1;
            end
            if (!module_en || clear) begin
                for (int v = 0; v < 2; v++) begin m_score[v] = 0; m_ovf[v] = 1'b0; end
                m_phase = 0;
            end else if (m_phase == 0) begin
                if (add_valid) begin
                    for (int v = 0; v < 2; v++) m_old[v] = m_score[v];
                    m_add = clamp_val(add_value);
                    m_phase = 1;
                end
            end else if (m_phase <= D) begin
                // After k digit steps the low k digits hold the sum, the upper digits are untouched.
                for (int v = 0; v < 2; v++)
                    m_score[v] = (m_old[v] / pow10(m_phase)) * pow10(m_phase)
                               + ((m_old[v] % pow10(m_phase) + m_add % pow10(m_phase)) % pow10(m_phase));
                m_phase = m_phase + 1;
            end else begin
                for (int v = 0; v < 2; v++) begin
                    tot = m_old[v] + m_add;
                    if (tot >= pow10(D)) begin
                        m_ovf[v] = 1'b1;
                        m_score[v] = (v == 0) ? pow10(D) - 1 : tot % pow10(D);
                    end
                end
                m_phase = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("ready_s", 32'(rdy_s), 32'(m_phase == 0));
        chk("ready_w", 32'(rdy_w), 32'(m_phase == 0));
        chk("score_s", 32'(score_s), 32'(to_bcd(m_score[0])));
        chk("score_w", 32'(score_w), 32'(to_bcd(m_score[1])));
        chk("high_s", 32'(high_s), 32'(to_bcd(m_high[0])));
        chk("high_w", 32'(high_w), 32'(to_bcd(m_high[1])));
        chk("ovf_s", 32'(ovf_s), 32'(m_ovf[0]));
        chk("ovf_w", 32'(ovf_w), 32'(m_ovf[1]));
        chk("char_s", 32'(ch_s), 32'(exp_char(m_score[0], m_high[0], char_xy)));
        chk("char_w", 32'(ch_w), 32'(exp_char(m_score[1], m_high[1], char_xy)));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_add(input logic [7:0] v);
        int n = 0;
        while (!rdy_s && n < 40) begin step(); n++; end
        chk("ready_before_add", 32'(rdy_s), 32'd1);
        add_valid = 1'b1;
        add_value = v;
        step();
        add_valid = 1'b0;
        n = 0;
        while (!rdy_s && n < 20) begin n++; step(); end
        last_busy = n;
        chk("ready_after_add", 32'(rdy_s), 32'd1);
    endtask

    task automatic pulse_clear();
        clear = 1'b1; step(); clear = 1'b0;
    endtask

    task automatic pulse_commit();
        commit = 1'b1; step(); commit = 1'b0;
    endtask

    initial begin
        int n;
        repeat (2) step();
        chk("rst_score", 32'(score_s), 32'h0);
        chk("rst_high", 32'(high_s), 32'h0);
        chk("rst_ovf", 32'(ovf_s), 32'h0);
        chk("rst_ready", 32'(rdy_s), 32'h1);
        rst_n = 1'b1; module_en = 1'b1;
        step();

        // Three +5 increments, each busy for DIGITS+1 cycles.
        for (int i = 0; i < 3; i++) begin
            do_add(8'h05);
            chk("busy_cycles", 32'(last_busy), 32'd4);
        end
        chk("t1_score", 32'(score_s), 32'h015);

        // High-score commit rules.
        pulse_clear(); do_add(8'h45); pulse_commit();
        chk("t4_high45", 32'(high_s), 32'h045);
        pulse_clear(); do_add(8'h99); do_add(8'h21);
        chk("t4_score120", 32'(score_s), 32'h120);
        pulse_commit();
        chk("t4_high120", 32'(high_s), 32'h120);
        pulse_clear(); do_add(8'h30); pulse_commit();
        chk("t4_high_kept", 32'(high_s), 32'h120);
        add_valid = 1'b1; add_value = 8'h99; step();
        add_valid = 1'b0; commit = 1'b1; step(); commit = 1'b0;
        n = 0;
        while (!rdy_s && n < 20) begin n++; step(); end
        step();
        chk("t4_high_pending", 32'(high_s), 32'h129);

        // Overflow: saturate vs wrap.
        pulse_clear();
        for (int i = 0; i < 10; i++) do_add(8'h99);
        do_add(8'h05);
        chk("t2_score995", 32'(score_s), 32'h995);
        do_add(8'h07);
        chk("t2_sat_score", 32'(score_s), 32'h999);
        chk("t2_sat_ovf", 32'(ovf_s), 32'h1);
        chk("t2_wrap_score", 32'(score_w), 32'h002);
        chk("t2_wrap_ovf", 32'(ovf_w), 32'h1);

        // Clear after one digit of an add.
        add_valid = 1'b1; add_value = 8'h11; step();
        add_valid = 1'b0; step();
        chk("t3_partial", 32'(score_s), 32'h990);
        pulse_clear();
        chk("t3_score", 32'(score_s), 32'h000);
        chk("t3_ovf", 32'(ovf_s), 32'h0);
        chk("t3_ready", 32'(rdy_s), 32'h1);
        chk("t3_high", 32'(high_s), 32'h129);

        // Character map with score 042, high 120.
        rst_n = 1'b0; step(); rst_n = 1'b1; step();
        do_add(8'h99); do_add(8'h21); pulse_commit();
        pulse_clear(); do_add(8'h42);
        char_xy = 8'h00; #1 chk("t5_S", 32'(ch_s), 32'h53);
        char_xy = 8'h50; #1 chk("t5_colon", 32'(ch_s), 32'h3A);
        char_xy = 8'h70; #1
`ifdef SCORE_LEADING_ZERO_BLANK_EN
        chk("t5_ms_digit", 32'(ch_s), 32'h20);
`else
        chk("t5_ms_digit", 32'(ch_s), 32'h30);
`endif
        char_xy = 8'h81; #1 chk("t5_high_mid", 32'(ch_s), 32'h32);
        char_xy = 8'h91; #1 chk("t5_high_ls", 32'(ch_s), 32'h30);
        char_xy = 8'hF0; #1 chk("t5_unmapped", 32'(ch_s), 32'h00);
        char_xy = 8'h82; #1 chk("t5_row2", 32'(ch_s), 32'h00);
        step();

        // Clamped addend digit, then asynchronous reset mid-add.
        pulse_clear(); do_add(8'h0C);
        chk("t6_clamp", 32'(score_s), 32'h009);
        add_valid = 1'b1; add_value = 8'h11; step();
        add_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_score", 32'(score_s), 32'h0);
        chk("t6_rst_high", 32'(high_s), 32'h0);
        chk("t6_rst_ovf", 32'(ovf_s), 32'h0);
        chk("t6_rst_ready", 32'(rdy_s), 32'h1);
        step();
        rst_n = 1'b1;
        step();

        // Randomized traffic checked by the model each cycle.
        for (int c = 0; c < 3000; c++) begin
            add_valid = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < AD; i++)
                add_value[4*i +: 4] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(10, 15))
                                                                   : 4'($urandom_range(0, 9));
            clear     = ($urandom_range(0, 39) == 0);
            module_en = ($urandom_range(0, 63) != 0);
            commit    = ($urandom_range(0, 5) == 0);
            char_xy   = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 3))};
            step();
        end
        add_valid = 1'b0; clear = 1'b0; commit = 1'b0; module_en = 1'b1;
        repeat (2) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/score_counter_bcd.md
Name: score_counter_bcd

Overview:
- Parametrised BCD score engine with text-character lookup for the in-game score/high-score overlay.
- Accepts multi-digit BCD increments through a valid/ready handshake.
- Adds them digit-serially, one digit per clock, LSB first.
- Tracks a high score and maps text-grid coordinates to ASCII codes for the existing text-draw/font-ROM path.

Parameters:
- DIGITS, 3, number of BCD digits in score and high score (1..8).
- ADD_DIGITS, 2, number of BCD digits in add_value (1..DIGITS).
- SATURATE, 1, 1 = clamp at all-9s on overflow; 0 = wrap modulo 10^DIGITS.
- LABEL_COL, 7, text column of the most significant digit.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- module_en  in  1  game running; low forces score to 0 and holds it there
- clear  in  1  synchronous score clear pulse
- add_valid  in  1  increment request
- add_ready  out  1  engine idle, can accept a request
- add_value  in  4*ADD_DIGITS  BCD increment, LSB digit in [3:0]
- commit  in  1  end-of-round pulse; updates the high score
- score_bcd  out  4*DIGITS  current score, BCD
- high_bcd  out  4*DIGITS  high score, BCD
- overflow  out  1  sticky overflow flag
- char_xy  in  8  [7:4] column, [3:0] row from the text-draw block
- char_code  out  7  ASCII code for that cell

Behaviour:
- Reset (rst_n low, asynchronous): score = 0, high = 0, overflow = 0, add_ready = 1, FSM = IDLE, commit_pend = 0.
- FSM states:
  - IDLE: add_ready = 1. The transfer is add_valid & add_ready & module_en & !clear. On transfer, latch add_value, zero the carry, set idx = 0, go to ADD.
  - ADD: add_ready = 0. Each cycle: sum = score[idx] + addend[idx] + carry. Addend digits with idx ≥ ADD_DIGITS are 0. Addend digits > 9 are clamped to 9. If sum > 9, write sum−10 and set carry = 1; otherwise write sum and carry = 0. Increment idx. After idx = DIGITS−1, go to DONE.
  - DONE: one cycle. If the final carry = 1, set overflow = 1. If SATURATE = 1, also force all digits to 9; if SATURATE = 0, keep the wrapped digits. Return to IDLE.
- Latency: an accept at edge N gives the final score_bcd visible after edge N+DIGITS+1. add_ready returns high in the cycle after DONE. Partial updates are visible on score_bcd during ADD.
- clear (or module_en low) has priority over everything. It aborts ADD/DONE, sets score = 0, overflow = 0, FSM = IDLE, and drops the in-flight increment. It does not affect high_bcd or commit_pend.
- commit:
  - In IDLE: if score > high, high = score. The comparison is an unsigned compare of the concatenated BCD vector, which is order-preserving.
  - While not IDLE: set commit_pend, then execute the commit in the first IDLE cycle.
  - commit and clear in the same cycle: the commit uses the pre-clear score.
- add_valid while add_ready = 0 is ignored; the requester must hold it.
- Character map, combinational (same cycle as char_xy):
  - Row 0: cols 0..5 = "Score:", col 6 = " ".
  - Row 1: cols 0..5 = "Best: ", col 6 = " ".
  - Cols LABEL_COL..LABEL_COL+DIGITS−1 = 0x30 + digit, MS digit first. Row 0 shows score, row 1 shows high.
  - All other cells: 0x00.

Optional Feature:
- Macro SCORE_LEADING_ZERO_BLANK_EN.
- Defined: leading zero digits (MS side) display as " " (0x20). The least-significant digit is always shown, so a score of 0 displays as "  0".
- Not defined: all digits are always displayed, e.g. "007".

Test Plan:
1. Reset, then add 0x05 three times (DIGITS=3) -> score_bcd 0x015. add_ready is low for exactly 4 cycles after each accept.
2. Score 0x995, add 0x07, SATURATE=1 -> score 0x999, overflow=1. Same case with SATURATE=0 -> score 0x002, overflow=1.
3. Assert clear mid-ADD (after 1 digit processed) -> score 0x000, overflow 0, add_ready 1 next cycle, high_bcd unchanged.
4. Score 0x120, high 0x045, commit in IDLE -> high 0x120. Then score 0x030 with commit -> high stays 0x120. A commit issued during ADD is applied in the first IDLE cycle against the final sum.
5. char_xy 0x00/0x50/0x70/0x81 with score 0x042, high 0x120 -> "S", ":", "0" (or " " with macro), "2". Unmapped 0xF0 -> 0x00.
6. Drop rst_n asynchronously mid-ADD -> all outputs return to reset values immediately. An add_value digit of 0xC is added as 9.
